fetch_queue: RTL and testbench

FETCH_QUEUE -- requirements
Module: fetch_queue

---
 rtl/fetch_pkg.sv | 14 +
 rtl/fetch_fifo.sv | 51 +++++
 rtl/fetch_queue.sv | 78 +++++++
 tb/tb_fetch_queue.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared fetch-stage types: the queued entry layout and the canonical NOP encoding.
package fetch_pkg;

  localparam int unsigned FetchXlen = 32;

  // The pc field is first so a packed entry reads as {pc, instr}.
  typedef struct packed {
    logic [FetchXlen-1:0] pc;
    logic [FetchXlen-1:0] instr;
  } fetch_entry_t;

  localparam logic [FetchXlen-1:0] NOP = 32'h00000013;

endpackage

// File: rtl/fetch_fifo.sv
// Circular prefetch storage with a synchronous flush. The caller never
// writes when the FIFO is full and never reads when it is empty.
module fetch_fifo #(
  parameter int Depth = 4,
  parameter int Width = 64
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   wr_en,
  input  logic [Width-1:0]       wr_data,
  input  logic                   rd_en,
  output logic [Width-1:0]       rd_data,
  output logic [$clog2(Depth):0] count
);

  localparam int PtrW = $clog2(Depth);

  logic [Width-1:0] mem [Depth];
  logic [PtrW-1:0]  wr_ptr;
  logic [PtrW-1:0]  rd_ptr;

  // NOTE: non-blocking (<=) for all sequential state so every register samples pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PtrW'(1);
      if (rd_en) rd_ptr <= rd_ptr + PtrW'(1);
      case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage is deliberately not reset; an empty FIFO's head is masked downstream.
  always_ff @(posedge clock) begin
    if (wr_en && !flush) mem[wr_ptr] <= wr_data;
  end

  assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/fetch_queue.sv
// Instruction prefetch: issues sequential word reads, tags the one-cycle
// responses with their PC and queues them for decode; redirect restarts fetch.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int                   DataWidth = 32,
  parameter int                   AddrWidth = 10,
  parameter int                   Depth     = 4,
  parameter logic [DataWidth-1:0] ResetPC   = '0
) (
  input  logic                       clock,
  input  logic                       reset,
  output logic                       imem_req,
  output logic [AddrWidth-1:0]       imem_addr,
  input  logic [DataWidth-1:0]       imem_rdata,
  input  logic                       redirect,
  input  logic [DataWidth-1:0]       redirect_target,
  input  logic                       deq_ready,
  output logic                       deq_valid,
  output logic [DataWidth-1:0]       deq_instr,
  output logic [DataWidth-1:0]       deq_pc,
  output logic [$clog2(Depth):0]     occupancy
);

  localparam int OccW = $clog2(Depth) + 1;

  logic [DataWidth-1:0]   fetch_pc;
  logic [DataWidth-1:0]   inflight_pc;
  logic                   inflight;
  logic [OccW:0]          pending;
  logic                   enq;
  logic                   deq;
  logic [2*DataWidth-1:0] head;

  // Counting the in-flight slot guarantees its response always has room.
  assign pending   = {1'b0, occupancy} + {{OccW{1'b0}}, inflight};
  assign imem_req  = !reset && !redirect && (pending < (OccW+1)'(Depth));
  assign imem_addr = fetch_pc[AddrWidth+1:2];

  assign enq       = inflight && !redirect;
  assign deq_valid = (occupancy != '0) && !redirect;
  assign deq       = deq_valid && deq_ready;

  assign deq_pc    = deq_valid ? head[2*DataWidth-1:DataWidth] : '0;
  assign deq_instr = deq_valid ? head[DataWidth-1:0]           : '0;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fetch_pc    <= ResetPC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
    end else if (redirect) begin
      fetch_pc <= {redirect_target[DataWidth-1:2], 2'b00};
      inflight <= 1'b0;
    end else begin
      inflight <= imem_req;
      if (imem_req) begin
        inflight_pc <= fetch_pc;
        fetch_pc    <= fetch_pc + DataWidth'(4);
      end
    end
  end

  fetch_fifo #(
    .Depth (Depth),
    .Width (2*DataWidth)
  ) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .flush   (redirect),
    .wr_en   (enq),
    .wr_data ({inflight_pc, imem_rdata}),
    .rd_en   (deq),
    .rd_data (head),
    .count   (occupancy)
  );

endmodule

// File: tb/tb_fetch_queue.sv
// Directed and random stimulus against a queue-based reference of the fetch stage.
module tb_fetch_queue;
  import fetch_pkg::*;

  localparam int Depth = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic        imem_req, imem_req2;
  logic [9:0]  imem_addr, imem_addr2;
  logic [31:0] imem_rdata, imem_rdata2;
  logic        redirect;
  logic [31:0] redirect_target;
  logic        deq_ready;
  logic        deq_valid, deq_valid2;
  logic [31:0] deq_instr, deq_instr2, deq_pc, deq_pc2;
  logic [2:0]  occupancy, occupancy2;
  logic [9:0]  addr_q, addr2_q;

  always #5 clock = ~clock;

  fetch_queue dut (
    .clock(clock), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .redirect(redirect), .redirect_target(redirect_target),
    .deq_ready(deq_ready), .deq_valid(deq_valid), .deq_instr(deq_instr),
    .deq_pc(deq_pc), .occupancy(occupancy)
  );

  fetch_queue #(.ResetPC(32'h0000_0FFC)) dut_wrap (
    .clock(clock), .reset(reset), .imem_req(imem_req2), .imem_addr(imem_addr2),
    .imem_rdata(imem_rdata2), .redirect(1'b0), .redirect_target(32'h0),
    .deq_ready(1'b1), .deq_valid(deq_valid2), .deq_instr(deq_instr2),
    .deq_pc(deq_pc2), .occupancy(occupancy2)
  );

  function automatic logic [31:0] mem_word(logic [9:0] a);
    return (32'(a) * 32'h9E37_79B1) ^ NOP;
  endfunction

  // Instruction memory: one-cycle read latency.
  always @(posedge clock) begin
    addr_q  <= imem_addr;
    addr2_q <= imem_addr2;
  end
  assign imem_rdata  = mem_word(addr_q);
  assign imem_rdata2 = mem_word(addr2_q);

  int errors = 0;
  int checks = 0;

  fetch_entry_t q[$];
  logic [31:0]  m_pc;
  logic [31:0]  m_infl_pc;
  bit           m_infl;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset(input logic [31:0] rpc);
    q.delete();
    m_pc      = rpc;
    m_infl    = 0;
    m_infl_pc = '0;
  endtask

  // Called just after a falling edge: drive, check, advance the model, move to the next falling edge.
  task automatic cycle(input logic redir, input logic [31:0] tgt, input logic rdy);
    bit exp_valid, exp_req;
    redirect        = redir;
    redirect_target = tgt;
    deq_ready       = rdy;
    #1;
    exp_valid = !redir && (q.size() > 0);
    exp_req   = !redir && ((q.size() + int'(m_infl)) < Depth);
    check("occupancy", 32'(occupancy), 32'(q.size()));
    check("deq_valid", 32'(deq_valid), 32'(exp_valid));
    check("imem_req",  32'(imem_req),  32'(exp_req));
    check("imem_addr", 32'(imem_addr), 32'(m_pc[11:2]));
    if (exp_valid) begin
      check("deq_pc",    deq_pc,    q[0].pc);
      check("deq_instr", deq_instr, q[0].instr);
    end
    if (redir) begin
      q.delete();
      m_infl = 0;
      m_pc   = {tgt[31:2], 2'b00};
    end else begin
      if (exp_valid && rdy) void'(q.pop_front());
      if (m_infl) q.push_back('{pc: m_infl_pc, instr: mem_word(m_infl_pc[11:2])});
      if (exp_req) begin
        m_infl_pc = m_pc;
        m_pc      = m_pc + 32'd4;
      end
      m_infl = exp_req;
    end
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_occupancy"}, 32'(occupancy), 32'd0);
    check({tag, "_deq_valid"}, 32'(deq_valid), 32'd0);
    check({tag, "_imem_req"},  32'(imem_req),  32'd0);
    check({tag, "_deq_instr"}, deq_instr,      32'd0);
    check({tag, "_deq_pc"},    deq_pc,         32'd0);
    check({tag, "_imem_addr"}, 32'(imem_addr), 32'd0);
  endtask

  initial begin
    reset           = 1'b1;
    redirect        = 1'b0;
    redirect_target = '0;
    deq_ready       = 1'b1;
    repeat (2) @(negedge clock);
    check_reset_outputs("reset");
    check("wrap_reset_addr", 32'(imem_addr2), 32'h3FF);
    check("wrap_reset_req",  32'(imem_req2),  32'd0);

    // Reset release: sequential fetch, one instruction per cycle.
    reset = 1'b0;
    model_reset(32'h0);
    for (int i = 0; i < 10; i++) begin
      #1;
      case (i)
        0: begin
          check("wrap_req0",  32'(imem_req2),  32'd1);
          check("wrap_addr0", 32'(imem_addr2), 32'h3FF);
        end
        1: check("wrap_addr1", 32'(imem_addr2), 32'h000);
        2: begin
          check("wrap_valid2", 32'(deq_valid2), 32'd1);
          check("wrap_pc2",    deq_pc2,         32'h0000_0FFC);
          check("wrap_instr2", deq_instr2,      mem_word(10'h3FF));
        end
        3: begin
          check("wrap_pc3",    deq_pc2,    32'h0000_1000);
          check("wrap_instr3", deq_instr2, mem_word(10'h000));
        end
        default: ;
      endcase
      cycle(1'b0, 32'h0, 1'b1);
    end

    // Back-pressure: queue fills to Depth, then drains with no loss or duplication.
    for (int i = 0; i < 10; i++) cycle(1'b0, 32'h0, 1'b0);
    check("saturated_occupancy", 32'(occupancy), 32'd4);
    check("saturated_req",       32'(imem_req),  32'd0);
    for (int i = 0; i < 12; i++) cycle(1'b0, 32'h0, 1'b1);

    // Build three queued entries plus one in flight, then redirect to 0x40.
    cycle(1'b1, 32'h0000_0100, 1'b1);
    for (int i = 0; i < 10 && !(q.size() == 3 && m_infl); i++) cycle(1'b0, 32'h0, 1'b0);
    check("pre_redirect_occupancy", 32'(occupancy), 32'd3);
    cycle(1'b1, 32'h0000_0040, 1'b1);
    redirect = 1'b0;
    #1;
    check("post_redirect_occupancy", 32'(occupancy), 32'd0);
    check("post_redirect_addr",      32'(imem_addr), 32'h10);
    for (int i = 0; i < 5; i++) cycle(1'b0, 32'h0, 1'b1);

    // Misaligned target is forced to a word boundary.
    cycle(1'b1, 32'h0000_0043, 1'b1);
    redirect = 1'b0;
    #1;
    check("misaligned_addr", 32'(imem_addr), 32'h10);
    for (int i = 0; i < 5; i++) cycle(1'b0, 32'h0, 1'b1);

    // Random traffic.
    for (int i = 0; i < 400; i++)
      cycle(($urandom_range(15) == 0), $urandom, 1'($urandom_range(1)));

    // Fill the queue, then assert reset between clock edges.
    for (int i = 0; i < 12; i++) cycle(1'b0, 32'h0, 1'b0);
    check("full_before_reset", 32'(occupancy), 32'd4);
    #2;
    reset = 1'b1;
    #1;
    check_reset_outputs("async_reset");
    @(negedge clock);
    reset = 1'b0;
    model_reset(32'h0);
    for (int i = 0; i < 20; i++) cycle(1'b0, 32'h0, 1'($urandom_range(1)));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
